hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_pkg.sv | 19 +
 rtl/hazard_mdu_cnt.sv | 35 +++
 rtl/hazard_ctrl.sv | 123 ++++++++++++
 tb/tb_hazard_ctrl.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller: forward-select
// encodings and default MDU latencies.
package hazard_pkg;

  typedef logic [1:0] fwd_sel_t;

  localparam fwd_sel_t FWD_RF = 2'd0;
  localparam fwd_sel_t FWD_E  = 2'd1;
  localparam fwd_sel_t FWD_M  = 2'd2;
  localparam fwd_sel_t FWD_W  = 2'd3;

  localparam int DEF_MULT_CYCLES = 5;
  localparam int DEF_DIV_CYCLES  = 10;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/hazard_mdu_cnt.sv
// MDU busy counter: a start while idle loads the op latency, then counts
// down to zero; starts arriving while busy are dropped.
module hazard_mdu_cnt
  import hazard_pkg::*;
#(
  parameter int MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic is_div,
  output logic busy
);

  localparam int CNT_W = $clog2(max_int(MULT_CYCLES, DIV_CYCLES) + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_q != '0)
      cnt_d = cnt_q - CNT_W'(1);
    else if (start)
      cnt_d = is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign busy = (cnt_q != '0);

endmodule

// File: rtl/hazard_ctrl.sv
// Tuse/Tnew stall and forwarding controller for a 5-stage pipeline.
// Optional MDU interlock enabled by defining HAZARD_MDU_EN.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_AW      = 5,
  parameter int TNEW_W      = 2,
  parameter int MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] rs_d,
  input  logic [REG_AW-1:0] rt_d,
  input  logic [TNEW_W-1:0] tuse_rs_d,
  input  logic [TNEW_W-1:0] tuse_rt_d,
  input  logic [REG_AW-1:0] dst_e,
  input  logic [TNEW_W-1:0] tnew_e,
  input  logic              regwrite_e,
  input  logic              md_use_d,
  input  logic              md_start_e,
  input  logic              md_is_div_e,
  output logic              pc_en,
  output logic              if_id_en,
  output logic              id_ex_clr,
  output logic [1:0]        fwd_rs_d,
  output logic [1:0]        fwd_rt_d,
  output logic [1:0]        fwd_rs_e,
  output logic [1:0]        fwd_rt_e,
  output logic              md_busy,
  output logic [TNEW_W-1:0] tnew_m,
  output logic [REG_AW-1:0] dst_m,
  output logic [REG_AW-1:0] dst_w
);

  localparam int NSRC = 2;

  logic [REG_AW-1:0]            dst_m_q, dst_m_d, dst_w_q, dst_w_d;
  logic [TNEW_W-1:0]            tnew_m_q, tnew_m_d;
  logic [NSRC-1:0][REG_AW-1:0]  src_d, src_e_q, src_e_d;
  logic [NSRC-1:0][TNEW_W-1:0]  tuse_d;
  logic [NSRC-1:0]              src_stall;
  logic [NSRC-1:0][1:0]         fwd_d, fwd_e;
  logic                         stall, stall_data, stall_md;

  assign src_d  = {rt_d, rs_d};
  assign tuse_d = {tuse_rt_d, tuse_rs_d};

  // dst_m/dst_w are zeroed for non-writers, so a match on them implies a write.
  for (genvar g = 0; g < NSRC; g++) begin : g_src
    logic nz_d, hit_e, hit_m, hit_w, nz_e;
    assign nz_d  = (src_d[g] != '0);
    assign hit_e = nz_d && regwrite_e && (src_d[g] == dst_e);
    assign hit_m = nz_d && (src_d[g] == dst_m_q);
    assign hit_w = nz_d && (src_d[g] == dst_w_q);
    assign src_stall[g] = (hit_e && (tuse_d[g] < tnew_e)) ||
                          (hit_m && (tuse_d[g] < tnew_m_q));
    assign fwd_d[g] = (hit_e && tnew_e == '0)   ? FWD_E :
                      (hit_m && tnew_m_q == '0) ? FWD_M :
                      hit_w                     ? FWD_W : FWD_RF;

    assign nz_e = (src_e_q[g] != '0);
    assign fwd_e[g] = (nz_e && src_e_q[g] == dst_m_q && tnew_m_q == '0) ? FWD_M :
                      (nz_e && src_e_q[g] == dst_w_q)                    ? FWD_W : FWD_RF;
    assign src_e_d[g] = stall ? '0 : src_d[g];
  end

  assign stall_data = |src_stall;

`ifdef HAZARD_MDU_EN
  hazard_mdu_cnt #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES)
  ) u_mdu_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (md_start_e),
    .is_div (md_is_div_e),
    .busy   (md_busy)
  );
  assign stall_md = md_use_d && (md_start_e || md_busy);
`else
  logic unused_md;
  localparam int unused_cycles = MULT_CYCLES + DIV_CYCLES;
  assign unused_md = ^{md_use_d, md_start_e, md_is_div_e};
  assign md_busy   = 1'b0;
  assign stall_md  = 1'b0;
`endif

  assign stall     = stall_data | stall_md;
  assign pc_en     = ~stall;
  assign if_id_en  = ~stall;
  assign id_ex_clr = stall;

  always_comb begin
    dst_m_d  = regwrite_e ? dst_e : '0;
    tnew_m_d = (tnew_e == '0) ? '0 : tnew_e - TNEW_W'(1);
    dst_w_d  = dst_m_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dst_m_q  <= '0;
      dst_w_q  <= '0;
      tnew_m_q <= '0;
      src_e_q  <= '0;
    end else begin
      dst_m_q  <= dst_m_d;
      dst_w_q  <= dst_w_d;
      tnew_m_q <= tnew_m_d;
      src_e_q  <= src_e_d;
    end
  end

  assign fwd_rs_d = fwd_d[0];
  assign fwd_rt_d = fwd_d[1];
  assign fwd_rs_e = fwd_e[0];
  assign fwd_rt_e = fwd_e[1];
  assign tnew_m   = tnew_m_q;
  assign dst_m    = dst_m_q;
  assign dst_w    = dst_w_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl; MDU scenarios run when
// HAZARD_MDU_EN is defined, otherwise the MDU inputs are checked as ignored.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] rs_d, rt_d, dst_e;
  logic [1:0] tuse_rs_d, tuse_rt_d, tnew_e;
  logic       regwrite_e, md_use_d, md_start_e, md_is_div_e;
  logic       pc_en, if_id_en, id_ex_clr, md_busy;
  logic [1:0] fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, tnew_m;
  logic [4:0] dst_m, dst_w;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  hazard_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .rs_d(rs_d), .rt_d(rt_d), .tuse_rs_d(tuse_rs_d), .tuse_rt_d(tuse_rt_d),
    .dst_e(dst_e), .tnew_e(tnew_e), .regwrite_e(regwrite_e),
    .md_use_d(md_use_d), .md_start_e(md_start_e), .md_is_div_e(md_is_div_e),
    .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_clr(id_ex_clr),
    .fwd_rs_d(fwd_rs_d), .fwd_rt_d(fwd_rt_d), .fwd_rs_e(fwd_rs_e), .fwd_rt_e(fwd_rt_e),
    .md_busy(md_busy), .tnew_m(tnew_m), .dst_m(dst_m), .dst_w(dst_w)
  );

  task automatic idle();
    rs_d = 0; rt_d = 0; tuse_rs_d = 0; tuse_rt_d = 0;
    dst_e = 0; tnew_e = 0; regwrite_e = 0;
    md_use_d = 0; md_start_e = 0; md_is_div_e = 0;
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic flush();
    idle(); step(); step();
  endtask

  task automatic test_reset();
    idle();
    dst_e = 4; tnew_e = 2; regwrite_e = 1; rs_d = 4; tuse_rs_d = 0;
    #1;
    n_checks++; if (dst_m !== 5'd0) begin n_fail++; $display("FAIL reset_dst_m: got %0d want 0", dst_m); end
    n_checks++; if (dst_w !== 5'd0) begin n_fail++; $display("FAIL reset_dst_w: got %0d want 0", dst_w); end
    n_checks++; if (tnew_m !== 2'd0) begin n_fail++; $display("FAIL reset_tnew_m: got %0d want 0", tnew_m); end
    n_checks++; if (md_busy !== 1'b0) begin n_fail++; $display("FAIL reset_md_busy: got %0b want 0", md_busy); end
    n_checks++; if ({fwd_rs_e, fwd_rt_e} !== 4'd0) begin n_fail++; $display("FAIL reset_fwd_e: got %0d/%0d want 0/0", fwd_rs_e, fwd_rt_e); end
    n_checks++; if ({pc_en, if_id_en, id_ex_clr} !== 3'b001) begin n_fail++; $display("FAIL reset_stall_live: got %b want 001", {pc_en, if_id_en, id_ex_clr}); end
    idle(); #1;
    n_checks++; if ({pc_en, if_id_en, id_ex_clr} !== 3'b110) begin n_fail++; $display("FAIL reset_nostall: got %b want 110", {pc_en, if_id_en, id_ex_clr}); end
  endtask

  task automatic test_load_use();
    flush();
    dst_e = 2; tnew_e = 2; regwrite_e = 1; rs_d = 2; tuse_rs_d = 1; #1;
    n_checks++; if ({pc_en, if_id_en, id_ex_clr} !== 3'b001) begin n_fail++; $display("FAIL lw_stall_e: got %b want 001", {pc_en, if_id_en, id_ex_clr}); end
    step();
    dst_e = 0; tnew_e = 0; regwrite_e = 0; #1;
    n_checks++; if (tnew_m !== 2'd1 || dst_m !== 5'd2) begin n_fail++; $display("FAIL lw_m_regs: got tnew_m=%0d dst_m=%0d want 1/2", tnew_m, dst_m); end
    n_checks++; if (pc_en !== 1'b1 || fwd_rs_d !== 2'd0) begin n_fail++; $display("FAIL lw_m_tuse1: got pc_en=%0b fwd=%0d want 1/0", pc_en, fwd_rs_d); end
    n_checks++; if (fwd_rs_e !== 2'd0) begin n_fail++; $display("FAIL lw_bubble_e: got %0d want 0", fwd_rs_e); end
    tuse_rs_d = 0; #1;
    n_checks++; if (id_ex_clr !== 1'b1) begin n_fail++; $display("FAIL lw_m_tuse0_stall: got %0b want 1", id_ex_clr); end
    tuse_rs_d = 1; #1;
    step();
    n_checks++; if (dst_m !== 5'd0 || dst_w !== 5'd2 || tnew_m !== 2'd0) begin n_fail++; $display("FAIL lw_w_regs: got m=%0d w=%0d t=%0d want 0/2/0", dst_m, dst_w, tnew_m); end
    n_checks++; if (fwd_rs_d !== 2'd3 || fwd_rs_e !== 2'd3) begin n_fail++; $display("FAIL lw_fwd_w: got d=%0d e=%0d want 3/3", fwd_rs_d, fwd_rs_e); end
  endtask

  task automatic test_branch();
    flush();
    dst_e = 3; tnew_e = 1; regwrite_e = 1; rs_d = 3; tuse_rs_d = 0; #1;
    n_checks++; if (pc_en !== 1'b0) begin n_fail++; $display("FAIL br_stall: got pc_en=%0b want 0", pc_en); end
    step();
    dst_e = 0; tnew_e = 0; regwrite_e = 0; rt_d = 3; tuse_rt_d = 0; #1;
    n_checks++; if (pc_en !== 1'b1) begin n_fail++; $display("FAIL br_release: got pc_en=%0b want 1", pc_en); end
    n_checks++; if (fwd_rs_d !== 2'd2 || fwd_rt_d !== 2'd2) begin n_fail++; $display("FAIL br_fwd_m: got %0d/%0d want 2/2", fwd_rs_d, fwd_rt_d); end
    step();
    n_checks++; if (fwd_rs_e !== 2'd3 || fwd_rt_e !== 2'd3) begin n_fail++; $display("FAIL br_fwd_e_w: got %0d/%0d want 3/3", fwd_rs_e, fwd_rt_e); end
  endtask

  task automatic test_e_fwd();
    flush();
    dst_e = 6; tnew_e = 0; regwrite_e = 1; rs_d = 6; tuse_rs_d = 1; #1;
    n_checks++; if (fwd_rs_d !== 2'd1 || pc_en !== 1'b1) begin n_fail++; $display("FAIL efwd_d: got fwd=%0d pc_en=%0b want 1/1", fwd_rs_d, pc_en); end
    step();
    dst_e = 7; tnew_e = 1; rs_d = 0; #1;
    n_checks++; if (fwd_rs_e !== 2'd2) begin n_fail++; $display("FAIL efwd_m: got %0d want 2", fwd_rs_e); end
  endtask

  task automatic test_zero_addr();
    flush();
    dst_e = 0; tnew_e = 2; regwrite_e = 1; rs_d = 0; tuse_rs_d = 0; #1;
    n_checks++; if (pc_en !== 1'b1 || fwd_rs_d !== 2'd0) begin n_fail++; $display("FAIL zero_addr: got pc_en=%0b fwd=%0d want 1/0", pc_en, fwd_rs_d); end
    step(); step();
    n_checks++; if (fwd_rs_d !== 2'd0 || fwd_rs_e !== 2'd0) begin n_fail++; $display("FAIL zero_addr_mw: got %0d/%0d want 0/0", fwd_rs_d, fwd_rs_e); end
  endtask

  task automatic test_priority();
    flush();
    dst_e = 5; tnew_e = 0; regwrite_e = 1;
    step();
    rs_d = 5; tuse_rs_d = 1; #1;
    n_checks++; if (fwd_rs_d !== 2'd1) begin n_fail++; $display("FAIL prio_e_over_m: got %0d want 1", fwd_rs_d); end
    step();
    regwrite_e = 0; dst_e = 0; #1;
    n_checks++; if (fwd_rs_d !== 2'd2 || dst_w !== 5'd5) begin n_fail++; $display("FAIL prio_m_over_w: got fwd=%0d dst_w=%0d want 2/5", fwd_rs_d, dst_w); end
    step();
    n_checks++; if (fwd_rs_d !== 2'd3 || dst_m !== 5'd0) begin n_fail++; $display("FAIL prio_w: got fwd=%0d dst_m=%0d want 3/0", fwd_rs_d, dst_m); end
  endtask

`ifdef HAZARD_MDU_EN
  task automatic mdu_run(input logic is_div, input int want, input string nm);
    int cnt;
    flush();
    md_start_e = 1; md_is_div_e = is_div; #1;
    step();
    md_start_e = 0; md_use_d = 1; cnt = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (pc_en !== 1'b0) break;
      cnt++;
      step();
    end
    n_checks++; if (cnt != want) begin n_fail++; $display("FAIL %s_stall_len: got %0d want %0d", nm, cnt, want); end
    n_checks++; if (md_busy !== 1'b0) begin n_fail++; $display("FAIL %s_busy_fall: got %0b want 0", nm, md_busy); end
  endtask

  task automatic test_mdu();
    int cnt;
    mdu_run(1'b0, 5, "mult");
    mdu_run(1'b1, 10, "div");
    flush();
    md_start_e = 1; md_use_d = 1; #1;
    n_checks++; if (pc_en !== 1'b0) begin n_fail++; $display("FAIL md_start_stall: got %0b want 0", pc_en); end
    md_use_d = 0;
    step();
    md_start_e = 1; md_is_div_e = 1; md_use_d = 1; cnt = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (md_busy !== 1'b1) break;
      cnt++;
      step();
      md_start_e = 0;
    end
    n_checks++; if (cnt != 5) begin n_fail++; $display("FAIL md_busy_ignore_start: got %0d busy cycles want 5", cnt); end
  endtask
`else
  task automatic test_mdu();
    flush();
    md_start_e = 1; md_use_d = 1; md_is_div_e = 1; #1;
    n_checks++; if (pc_en !== 1'b1) begin n_fail++; $display("FAIL md_ignored_stall: got %0b want 1", pc_en); end
    step(); #1;
    n_checks++; if (md_busy !== 1'b0 || pc_en !== 1'b1) begin n_fail++; $display("FAIL md_ignored_busy: got busy=%0b pc_en=%0b want 0/1", md_busy, pc_en); end
  endtask
`endif

  task automatic test_reset_mid();
    flush();
    md_start_e = 1; md_is_div_e = 0; dst_e = 9; regwrite_e = 1; tnew_e = 2;
    step();
    md_start_e = 0;
    step(); step();
    rst_n = 0; #1;
    n_checks++; if (md_busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %0b want 0", md_busy); end
    n_checks++; if (dst_m !== 5'd0 || dst_w !== 5'd0 || tnew_m !== 2'd0) begin n_fail++; $display("FAIL rstmid_regs: got m=%0d w=%0d t=%0d want 0/0/0", dst_m, dst_w, tnew_m); end
    idle();
    rst_n = 1;
    step();
    n_checks++; if (md_busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_after: got %0b want 0", md_busy); end
  endtask

  initial begin
    rst_n = 0;
    idle();
    #2;
    test_reset();
    #2 rst_n = 1;
    test_load_use();
    test_branch();
    test_e_fwd();
    test_zero_addr();
    test_priority();
    test_mdu();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
